// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit and its data-memory port.
package load_store_unit_pkg;

  typedef logic [31:0] word;

  // Direction select carried on data_memory_interface_t.mem_en
  localparam logic MEM_READ_EN  = 1'b0;
  localparam logic MEM_WRITE_EN = 1'b1;

  typedef struct packed {
    logic mem_enable;
    logic mem_en;
    word  address;
    word  data_in;
  } data_memory_interface_t;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStore,
    StRmwRd,
    StRmwWr,
    StResp
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational byte/half lane handling: load extract + extend, store merge.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  word         i_load_word,
  input  word         i_merge_word,
  input  logic [15:0] i_store_data,
  output word         o_load_data,
  output word         o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane out of the read word and extend it to 32 bits
  always_comb begin
    w_byte = i_load_word[{i_lane, 3'b000} +: 8];
    w_half = i_load_word[{i_lane[1], 4'b0000} +: 16];
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {24'h000000, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data = {16'h0000, w_half};
      default: o_load_data = i_load_word;
    endcase
  end

  // Replace only the addressed byte/half of the previously read word
  always_comb begin
    o_merged = i_merge_word;
    case (i_funct3)
      F3_B:    o_merged[{i_lane, 3'b000} +: 8] = i_store_data[7:0];
      F3_H:    o_merged[{i_lane[1], 4'b0000} +: 16] = i_store_data;
      default: o_merged = i_merge_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns byte/half/word requests into word-only memory
// accesses, using read-modify-write for sub-word stores.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [2:0]             req_funct3,
  input  word                    req_addr,
  input  word                    req_wdata,
  output data_memory_interface_t mem_sig,
  input  word                    mem_rdata,
  output logic                   resp_valid,
  output word                    resp_rdata,
  output logic                   resp_misaligned,
  output logic                   resp_fault
);

  localparam logic [32:0] ByteLimit = 33'(64'(MEM_WORDS) * 64'd4);

  lsu_state_t  r_state, w_next;
  logic        r_write;
  logic [2:0]  r_funct3;
  word         r_addr;
  word         r_wdata;
  word         r_merge;
  word         r_rdata;
  logic        r_mis;
  logic        r_fault;

  logic        w_accept;
  logic        w_req_mis;
  logic        w_req_fault;
  word         w_load_data;
  word         w_merged;
  word         w_word_addr;

  assign w_accept    = req_valid && req_ready;
  assign w_req_fault = ({1'b0, req_addr} >= ByteLimit);
  assign w_word_addr = {r_addr[31:2], 2'b00};

  // Alignment check; illegal funct3 (and unsigned stores) fold into misaligned
  always_comb begin
    case (req_funct3)
      F3_B:    w_req_mis = 1'b0;
      F3_H:    w_req_mis = req_addr[0];
      F3_W:    w_req_mis = |req_addr[1:0];
      F3_BU:   w_req_mis = req_write;
      F3_HU:   w_req_mis = req_write | req_addr[0];
      default: w_req_mis = 1'b1;
    endcase
  end

  lsu_lane_align u_lane_align (
    .i_funct3     (r_funct3),
    .i_lane       (r_addr[1:0]),
    .i_load_word  (mem_rdata),
    .i_merge_word (r_merge),
    .i_store_data (r_wdata[15:0]),
    .o_load_data  (w_load_data),
    .o_merged     (w_merged)
  );

  // Next state, handshake and memory-port drive
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    mem_sig   = '0;
    case (r_state)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_mis || w_req_fault) begin
            w_next = StResp;
          end else if (req_write) begin
            w_next = (req_funct3 == F3_W) ? StStore : StRmwRd;
          end else begin
            w_next = StLoad;
          end
        end
      end
      StLoad, StRmwRd: begin
        mem_sig.mem_enable = 1'b1;
        mem_sig.mem_en     = MEM_READ_EN;
        mem_sig.address    = w_word_addr;
        w_next             = (r_state == StLoad) ? StResp : StRmwWr;
      end
      StStore: begin
        mem_sig.mem_enable = 1'b1;
        mem_sig.mem_en     = MEM_WRITE_EN;
        mem_sig.address    = w_word_addr;
        mem_sig.data_in    = r_wdata;
        w_next             = StResp;
      end
      StRmwWr: begin
        mem_sig.mem_enable = 1'b1;
        mem_sig.mem_en     = MEM_WRITE_EN;
        mem_sig.address    = w_word_addr;
        mem_sig.data_in    = w_merged;
        w_next             = StResp;
      end
      StResp:  w_next = StIdle;
      default: w_next = StIdle;
    endcase
    // A reset arriving mid-sequence must not let a pending write land
    if (reset) begin
      mem_sig = '0;
    end
  end

  // State register plus request/response capture
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= StIdle;
      r_write  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_merge  <= '0;
      r_rdata  <= '0;
      r_mis    <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write  <= req_write;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_mis    <= w_req_mis;
        r_fault  <= w_req_fault;
        r_rdata  <= '0;
      end
      if (r_state == StLoad) begin
        r_rdata <= w_load_data;
      end
      if (r_state == StRmwRd) begin
        r_merge <= mem_rdata;
      end
    end
  end

  // Response fields are forced to zero outside the single RESP cycle
  always_comb begin
    resp_valid      = (r_state == StResp);
    resp_misaligned = resp_valid & r_mis;
    resp_fault      = resp_valid & r_fault;
    resp_rdata      = (resp_valid && !r_write && !r_mis && !r_fault) ? r_rdata : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-wide behavioural memory.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic                   clock;
  logic                   reset;
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [2:0]             req_funct3;
  word                    req_addr;
  word                    req_wdata;
  data_memory_interface_t mem_sig;
  word                    mem_rdata;
  logic                   resp_valid;
  word                    resp_rdata;
  logic                   resp_misaligned;
  logic                   resp_fault;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .mem_sig         (mem_sig),
    .mem_rdata       (mem_rdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .resp_fault      (resp_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural data_memory: combinational read, write at posedge
  logic [31:0] mem [256];
  logic        mem_init;
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  assign mem_rdata = mem[mem_sig.address[9:2]];

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8]   <= 32'hCAFEF00D;
      mem[255] <= 32'h80000000;
    end else if (mem_sig.mem_enable) begin
      if (mem_sig.mem_en == MEM_WRITE_EN) begin
        mem[mem_sig.address[9:2]] <= mem_sig.data_in;
        wr_cnt <= wr_cnt + 1;
      end else begin
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mis;
    logic        fault;
    int          lat;
    int          reads;
    int          writes;
  } vec_t;

  localparam int NumVecs = 24;
  vec_t vecs [NumVecs];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    int rd0;
    int wr0;
    logic got;
    @(negedge clock);
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clock);
      lat++;
      if (resp_valid) got = 1'b1;
    end
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " rdata"}, resp_rdata, v.rdata);
    check({tag, " misaligned"}, 32'(resp_misaligned), 32'(v.mis));
    check({tag, " fault"}, 32'(resp_fault), 32'(v.fault));
    check({tag, " reads"}, 32'(rd_cnt - rd0), 32'(v.reads));
    check({tag, " writes"}, 32'(wr_cnt - wr0), 32'(v.writes));
    @(negedge clock);
    check({tag, " pulse end"}, {31'(resp_rdata != 0), resp_valid}, 32'd0);
  endtask

  initial begin
    vec_t rv;
    int   wr0;
    //          wr    f3    addr       wdata          rdata          mis   flt  lat rd wr
    vecs[0]  = '{1'b1, F3_W,  32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0, 2, 0, 1};
    vecs[1]  = '{1'b0, F3_W,  32'h010, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 2, 1, 0};
    vecs[2]  = '{1'b1, F3_B,  32'h011, 32'h000000AA, 32'h00000000, 1'b0, 1'b0, 3, 1, 1};
    vecs[3]  = '{1'b0, F3_W,  32'h010, 32'h0,        32'hDEADAAEF, 1'b0, 1'b0, 2, 1, 0};
    vecs[4]  = '{1'b0, F3_B,  32'h011, 32'h0,        32'hFFFFFFAA, 1'b0, 1'b0, 2, 1, 0};
    vecs[5]  = '{1'b0, F3_BU, 32'h011, 32'h0,        32'h000000AA, 1'b0, 1'b0, 2, 1, 0};
    vecs[6]  = '{1'b0, F3_H,  32'h012, 32'h0,        32'hFFFFDEAD, 1'b0, 1'b0, 2, 1, 0};
    vecs[7]  = '{1'b0, F3_HU, 32'h012, 32'h0,        32'h0000DEAD, 1'b0, 1'b0, 2, 1, 0};
    vecs[8]  = '{1'b0, F3_W,  32'h012, 32'h0,        32'h00000000, 1'b1, 1'b0, 1, 0, 0};
    vecs[9]  = '{1'b1, F3_W,  32'h400, 32'h12345678, 32'h00000000, 1'b0, 1'b1, 1, 0, 0};
    vecs[10] = '{1'b0, F3_W,  32'h402, 32'h0,        32'h00000000, 1'b1, 1'b1, 1, 0, 0};
    vecs[11] = '{1'b1, F3_H,  32'h013, 32'h1111,     32'h00000000, 1'b1, 1'b0, 1, 0, 0};
    vecs[12] = '{1'b1, F3_BU, 32'h010, 32'h22,       32'h00000000, 1'b1, 1'b0, 1, 0, 0};
    vecs[13] = '{1'b0, 3'b011, 32'h010, 32'h0,       32'h00000000, 1'b1, 1'b0, 1, 0, 0};
    vecs[14] = '{1'b1, F3_H,  32'h016, 32'hFFFF1234, 32'h00000000, 1'b0, 1'b0, 3, 1, 1};
    vecs[15] = '{1'b0, F3_W,  32'h014, 32'h0,        32'h12340000, 1'b0, 1'b0, 2, 1, 0};
    vecs[16] = '{1'b0, F3_H,  32'h016, 32'h0,        32'h00001234, 1'b0, 1'b0, 2, 1, 0};
    vecs[17] = '{1'b1, F3_B,  32'h013, 32'hFFFFFF7F, 32'h00000000, 1'b0, 1'b0, 3, 1, 1};
    vecs[18] = '{1'b0, F3_W,  32'h010, 32'h0,        32'h7FADAAEF, 1'b0, 1'b0, 2, 1, 0};
    vecs[19] = '{1'b0, F3_B,  32'h013, 32'h0,        32'h0000007F, 1'b0, 1'b0, 2, 1, 0};
    vecs[20] = '{1'b0, F3_B,  32'h3FF, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0, 2, 1, 0};
    vecs[21] = '{1'b0, F3_BU, 32'h400, 32'h0,        32'h00000000, 1'b0, 1'b1, 1, 0, 0};
    vecs[22] = '{1'b0, F3_W,  32'h3FC, 32'h0,        32'h80000000, 1'b0, 1'b0, 2, 1, 0};
    vecs[23] = '{1'b0, F3_H,  32'h010, 32'h0,        32'hFFFFAAEF, 1'b0, 1'b0, 2, 1, 0};

    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    reset      = 1'b1;
    mem_init   = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    mem_init = 1'b0;
    reset    = 1'b0;

    // Idle after reset: ready, no memory traffic, no response
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check($sformatf("idle%0d ready", c), 32'(req_ready), 32'd1);
      check($sformatf("idle%0d mem_enable", c), 32'(mem_sig.mem_enable), 32'd0);
      check($sformatf("idle%0d resp", c),
            {resp_rdata[29:0], resp_fault, resp_valid | resp_misaligned}, 32'd0);
    end

    for (int i = 0; i < NumVecs; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end
    check("mem[4] final", mem[4], 32'h7FADAAEF);
    check("mem[0] untouched", mem[0], 32'h00000000);

    // Reset during the RMW read of an SH must drop the write
    @(negedge clock);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = F3_H;
    req_addr   = 32'h20;
    req_wdata  = 32'h0000BEEF;
    wr0 = wr_cnt;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    check("rst mid mem_enable", 32'(mem_sig.mem_enable), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check($sformatf("rst idle%0d ready", c), 32'(req_ready), 32'd1);
      check($sformatf("rst idle%0d resp_valid", c), 32'(resp_valid), 32'd0);
    end
    check("rst no write", 32'(wr_cnt - wr0), 32'd0);
    check("rst mem[8]", mem[8], 32'hCAFEF00D);
    rv = '{1'b0, F3_W, 32'h020, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, 2, 1, 0};
    run_vec(rv, "post-reset LW");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
